bank_responder: RTL and testbench

- Responder end of the multibank requester protocol: one memory bank serving READ_PORTS read requesters and WRITE_PORTS write requesters.
- Provides the r_addr/r_avalid/r_aready/r_dvalid/r_data and w_addr/w_data/w_valid/w_ready handshakes.
- Round-robin arbitration onto a single-port storage array, one access per cycle.
- Fixed-latency, in-order read return per port; saturating contention counter for performance analysis.

---
 rtl/bank_responder.sv | 115 +++++++++++
 tb/tb_bank_responder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bank_responder.sv
// bank_responder: round-robin arbitrated single-port memory bank serving
// WRITE_PORTS writers and READ_PORTS readers with fixed-latency in-order reads.
module bank_responder #(
    parameter int READ_PORTS   = 3,
    parameter int WRITE_PORTS  = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]  r_addr,
    input  logic [READ_PORTS-1:0]             r_avalid,
    output logic [READ_PORTS-1:0]             r_aready,
    output logic [READ_PORTS-1:0]             r_dvalid,
    output logic [READ_PORTS*DATA_WIDTH-1:0]  r_data,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] w_addr,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] w_data,
    input  logic [WRITE_PORTS-1:0]            w_valid,
    output logic [WRITE_PORTS-1:0]            w_ready,
    output logic [31:0]                       stall_cnt
);
    localparam int N   = WRITE_PORTS + READ_PORTS;
    localparam int PW  = $clog2(N);
    localparam int RPW = READ_PORTS > 1 ? $clog2(READ_PORTS) : 1;
    localparam int L   = READ_LATENCY;

    logic [DATA_WIDTH-1:0] memory [2**ADDR_WIDTH];
    logic [N-1:0]          req, gnt;
    logic [PW-1:0]         rr_q, rr_d, win;
    logic                  hs, we, re;
    logic [ADDR_WIDTH-1:0] wa, ra;
    logic [DATA_WIDTH-1:0] wd;
    logic [RPW-1:0]        rp;
    logic [31:0]           stall_cnt_q, stall_d;
    logic [L-1:0]          v_q;
    logic [RPW-1:0]        p_q [L];
    logic [DATA_WIDTH-1:0] d_q [L];

    // Search from rr_q modulo N; grants are suppressed while reset is held
    always_comb begin
        req = {r_avalid, w_valid};
        gnt = '0;
        win = '0;
        hs  = 1'b0;
        for (int o = 0; o < N; o++)
            if (!hs && rst && req[PW'((int'(rr_q) + o) % N)]) begin
                hs  = 1'b1;
                win = PW'((int'(rr_q) + o) % N);
            end
        if (hs) gnt[win] = 1'b1;
        rr_d    = hs ? (win == PW'(N - 1) ? '0 : win + 1'b1) : rr_q;
        stall_d = ($countones(req) >= 2 && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    assign w_ready   = gnt[WRITE_PORTS-1:0];
    assign r_aready  = gnt[N-1:WRITE_PORTS];
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        we = 1'b0;
        wa = '0;
        wd = '0;
        re = 1'b0;
        ra = '0;
        rp = '0;
        for (int j = 0; j < WRITE_PORTS; j++)
            if (gnt[j]) begin
                we = 1'b1;
                wa = w_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                wd = w_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        for (int j = 0; j < READ_PORTS; j++)
            if (gnt[WRITE_PORTS+j]) begin
                re = 1'b1;
                ra = r_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                rp = RPW'(j);
            end
    end

    always_ff @(posedge clk)
        if (we) memory[wa] <= wd;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rr_q        <= '0;
            stall_cnt_q <= '0;
            v_q         <= '0;
            for (int s = 0; s < L; s++) begin
                p_q[s] <= '0;
                d_q[s] <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            stall_cnt_q <= stall_d;
            v_q[0]      <= re;
            p_q[0]      <= rp;
            d_q[0]      <= memory[ra];
            for (int s = 1; s < L; s++) begin
                v_q[s] <= v_q[s-1];
                p_q[s] <= p_q[s-1];
                d_q[s] <= d_q[s-1];
            end
        end

    always_comb begin
        r_dvalid = '0;
        r_data   = '0;
        for (int j = 0; j < READ_PORTS; j++)
            if (v_q[L-1] && p_q[L-1] == RPW'(j)) begin
                r_dvalid[j]                      = 1'b1;
                r_data[j*DATA_WIDTH +: DATA_WIDTH] = d_q[L-1];
            end
    end
endmodule

// File: tb/tb_bank_responder.sv
// tb_bank_responder: directed plus random stimulus checked against a queue-based
// reference model of the bank's arbitration, storage and read return.
module tb_bank_responder;
    localparam int L = 2;

    logic        clk, rst;
    logic [23:0] r_addr;
    logic [2:0]  r_avalid, r_aready, r_dvalid;
    logic [47:0] r_data;
    logic [23:0] w_addr;
    logic [47:0] w_data;
    logic [2:0]  w_valid, w_ready;
    logic [31:0] stall_cnt;

    bank_responder dut (
        .clk(clk), .rst(rst),
        .r_addr(r_addr), .r_avalid(r_avalid), .r_aready(r_aready),
        .r_dvalid(r_dvalid), .r_data(r_data),
        .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {int port; logic [15:0] data; int due;} rd_t;
    rd_t         rq[$];
    logic [15:0] mem_m [256];
    int          rr_m, cyc, total, bad;
    logic [31:0] stall_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check settled outputs against the model, then commit the edge
    task automatic step();
        int          g;
        logic [5:0]  req;
        logic [2:0]  edv;
        logic [47:0] erd;
        rd_t         e;
        #1;
        req = {r_avalid, w_valid};
        g   = -1;
        if (rst)
            for (int o = 0; o < 6; o++)
                if (g < 0 && req[(rr_m + o) % 6]) g = (rr_m + o) % 6;
        chk("grant", {r_aready, w_ready}, g < 0 ? 64'd0 : 64'd1 << g);
        edv = '0;
        erd = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e = rq.pop_front();
            edv[e.port] = 1'b1;
            erd[e.port*16 +: 16] = e.data;
        end
        chk("dvalid", r_dvalid, edv);
        chk("rdata", r_data, erd);
        chk("stall", stall_cnt, stall_m);
        @(posedge clk);
        if (rst) begin
            if (g >= 0 && g < 3) mem_m[w_addr[g*8 +: 8]] = w_data[g*16 +: 16];
            if (g >= 3) rq.push_back('{g - 3, mem_m[r_addr[(g-3)*8 +: 8]], cyc + L});
            if (g >= 0) rr_m = (g + 1) % 6;
            if ($countones(req) >= 2 && stall_m != 32'hFFFF_FFFF) stall_m++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        w_valid  = '0;
        r_avalid = '0;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; rr_m = 0; stall_m = '0;
        rst = 1'b0; idle(); r_addr = '0; w_addr = '0; w_data = '0;
        @(negedge clk);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w_valid = 3'b001; w_addr[7:0] = 8'(i); w_data[15:0] = 16'(i);
            step();
        end
        idle(); step();
        // Single read of address 5 from read port 0
        r_avalid = 3'b001; r_addr[7:0] = 8'h05; step();
        idle(); step(); step(); step();
        // Read before write, write, then read after write at 0x10
        r_avalid = 3'b001; r_addr[7:0] = 8'h10; step();
        idle(); w_valid = 3'b010; w_addr[15:8] = 8'h10; w_data[31:16] = 16'hBEEF; step();
        idle(); r_avalid = 3'b100; r_addr[23:16] = 8'h10; step();
        idle(); step(); step(); step();
        // All six requesters valid continuously
        w_addr = {8'h32, 8'h31, 8'h30}; w_data = {16'h3333, 16'h2222, 16'h1111};
        r_addr = {8'h30, 8'h02, 8'h01};
        w_valid = 3'b111; r_avalid = 3'b111;
        for (int i = 0; i < 13; i++) step();
        idle(); step(); step(); step();
        // Back-to-back reads on read port 1
        for (int i = 1; i <= 4; i++) begin
            r_avalid = 3'b010; r_addr[15:8] = 8'(i); step();
        end
        idle(); for (int i = 0; i < 4; i++) step();
        // Reset while a read is in flight
        r_avalid = 3'b001; r_addr[7:0] = 8'h07; step();
        rst = 1'b0; rq.delete(); rr_m = 0; stall_m = '0;
        w_valid = 3'b110; r_avalid = 3'b011;
        step(); step();
        rst = 1'b1; w_valid = 3'b100; r_avalid = 3'b010;
        step();
        idle(); step(); step(); step();
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            w_valid = 3'($urandom); r_avalid = 3'($urandom);
            for (int j = 0; j < 3; j++) begin
                w_addr[j*8 +: 8]   = 8'($urandom_range(0, 15));
                r_addr[j*8 +: 8]   = 8'($urandom_range(0, 15));
                w_data[j*16 +: 16] = 16'($urandom);
            end
            step();
        end
        idle(); for (int i = 0; i < 4; i++) step();
        // Saturation of the contention counter
        w_valid = 3'b001; r_avalid = 3'b001; w_addr[7:0] = 8'h40; r_addr[7:0] = 8'h41;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        stall_m = 32'hFFFF_FFFE;
        #2;
        release dut.stall_cnt_q;
        step(); step(); step();
        idle(); step(); step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
